spi_slave_core: RTL
===================

// Module: spi_slave_core
// PURPOSE
//  SPI slave endpoint on the slave side of spi_bus: mode 0 (CPOL=0, CPHA=0), MSB first.
//  Deserialises MOSI frames into a valid/ready RX stream.
//  Serialises TX-stream words onto MISO.
//  CS_N/SCK/MOSI are oversampled in the system clk domain; SCK must be <= clk/4.
// PARAMETERS
//  DATA_W     8   bits per SPI frame (>=2)
//  SYNC_STG   2   synchroniser flops on cs_n/sck/mosi (>=2)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  cs_n         in   1       SPI chip select, active low
//  sck          in   1       SPI serial clock from master
//  mosi         in   1       master-out serial data
//  miso         out  1       slave-out serial data (driven 0 when deselected)
//  rx_data      out  DATA_W  received word, stable while rx_valid=1
//  rx_valid     out  1       received word available
//  rx_ready     in   1       downstream accepts word (transfer = valid & ready)
//  tx_data      in   DATA_W  word to send in next frame
//  tx_valid     in   1       tx_data available
//  tx_ready     out  1       1-cycle pulse: tx_data captured into shifter
//  rx_overflow  out  1       1-cycle pulse: completed frame dropped (rx_valid still held)
//  tx_underrun  out  1       1-cycle pulse: frame started with tx_valid=0, zeros sent
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, bit counter 0, shifters 0. Async assert, sync release.
//  Sync: cs_n/sck/mosi each pass SYNC_STG flops.
//   Edge detect on synced sck: rise_p, fall_p; on synced cs_n: sel_p (1->0), desel_p (0->1).
//  FSM IDLE:
//   sel_p -> LOAD.
//  FSM LOAD (1 cycle):
//   tx_valid=1: tx_sh<=tx_data, tx_ready=1.
//   tx_valid=0: tx_sh<=0, tx_underrun=1.
//   miso<=MSB of the loaded value; bit_cnt<=0; -> SHIFT.
//  FSM SHIFT:
//   rise_p: rx_sh<={rx_sh[DATA_W-2:0],mosi_s}; bit_cnt++.
//   fall_p with bit_cnt in 1..DATA_W-1: tx_sh<<=1; miso<=next bit.
//   rise_p with bit_cnt==DATA_W-1 completes a frame:
//    bit_cnt<=0; go to RELOAD.
//    rx_valid=0, or rx_valid=1 & rx_ready=1 in the same cycle: rx_data<=complete word,
//     rx_valid<=1.
//    rx_valid=1 & rx_ready=0: word discarded, rx_overflow=1, rx_data unchanged.
//  FSM RELOAD:
//   Waits for the next fall_p, then performs the LOAD action (tx_ready or tx_underrun)
//   -> SHIFT. This supports back-to-back frames under one cs_n low.
//  desel_p in any state -> IDLE, same cycle:
//   partial frame dropped, no rx_valid; bit_cnt<=0; miso<=0.
//   A completed frame already in rx_data is kept.
//  rx_valid clears the cycle after rx_valid & rx_ready, unless a new frame completes
//   in that cycle.
//  Master timing rules (the bench enforces them):
//   >= SYNC_STG+3 clk from cs_n fall to the first sck rise;
//   sck high and low >= 2 clk each.
//  RX latency: rx_valid rises SYNC_STG+2 clk after the clk edge that first samples
//   the last sck high.
//  miso: changes only in LOAD/RELOAD or on fall_p; 0 in IDLE.
//  Widths: bit_cnt is $clog2(DATA_W) bits; no arithmetic beyond the counter increment.
// STRUCTURE
//  spi_pkg: SPI_DATA_W default, state enum spi_slv_state_e {IDLE,LOAD,SHIFT,RELOAD}.
//  Sub-module spi_sync_edge: SYNC_STG-flop synchroniser plus rise/fall pulse outputs.
//   Instantiated 3x (cs_n, sck, mosi; mosi edge outputs unused).
//  Top level: FSM, shifters, bit counter, RX holding register.
// TESTING
//  1. tx_data=8'hA5 valid, master sends 8'h3C in one frame.
//     -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; tx_ready one pulse at selection.
//  2. Two frames under one cs_n (8'h01, 8'hFE), rx_ready=1.
//     -> two rx handshakes in order; tx words 8'h11, 8'h22 shifted out back-to-back.
//  3. rx_ready=0, two frames 8'h55, 8'hAA.
//     -> rx_data stays 8'h55, rx_overflow pulses once at the second frame's end.
//  4. tx_valid=0 at cs_n fall.
//     -> tx_underrun pulses once; MISO all 0; the RX frame is still received correctly.
//  5. cs_n raised after 5 of 8 sck pulses, then a full frame 8'h81.
//     -> no rx_valid for the partial frame; next rx_data=8'h81.
//  6. rst_n asserted mid-frame (bit 4).
//     -> all outputs 0 immediately; after release, a full frame is received normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave endpoint.
package spi_pkg;

  localparam int SPI_DATA_W   = 8;
  localparam int SPI_SYNC_STG = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    RELOAD = 2'd3
  } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with registered
// rising/falling edge pulses taken from the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise_p,
  output logic fall_p
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;

  // dout is retimed once more so the data level and the edge pulses of
  // every instance line up at the same cycle for the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STG{RST_VAL}};
      dout   <= RST_VAL;
      prev_q <= RST_VAL;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      dout   <= sync_q[SYNC_STG-1];
      prev_q <= dout;
      rise_p <= dout & ~prev_q;
      fall_p <= ~dout & prev_q;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave endpoint: oversampled cs_n/sck/mosi, MSB-first shifters,
// valid/ready RX stream and TX stream, back-to-back frames under one select.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int SYNC_STG = SPI_SYNC_STG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overflow,
  output logic              tx_underrun
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_n_s_unused, sck_s_unused, mosi_rise_unused, mosi_fall_unused;
  logic sel_p, desel_p, rise_p, fall_p, mosi_s;

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .dout(cs_n_s_unused), .rise_p(desel_p), .fall_p(sel_p)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .dout(sck_s_unused), .rise_p(rise_p), .fall_p(fall_p)
  );

  spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .dout(mosi_s), .rise_p(mosi_rise_unused), .fall_p(mosi_fall_unused)
  );

  spi_slv_state_e     state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [DATA_W-1:0]  ld_word;
  logic [DATA_W-1:0]  rx_word;

  // An absent TX word is replaced by zeros rather than stale tx_data.
  assign ld_word = tx_valid ? tx_data : '0;
  assign rx_word = {rx_sh[DATA_W-2:0], mosi_s};

  // Deselect overrides everything; a word already held in rx_data survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overflow <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (desel_p) begin
        state   <= IDLE;
        bit_cnt <= '0;
        tx_sh   <= '0;
        rx_sh   <= '0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sel_p) begin
              state <= LOAD;
            end
          end
          LOAD: begin
            tx_sh       <= ld_word;
            miso        <= ld_word[DATA_W-1];
            tx_ready    <= tx_valid;
            tx_underrun <= ~tx_valid;
            bit_cnt     <= '0;
            state       <= SHIFT;
          end
          SHIFT: begin
            if (rise_p) begin
              rx_sh <= rx_word;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= RELOAD;
                if (!rx_valid || rx_ready) begin
                  rx_data  <= rx_word;
                  rx_valid <= 1'b1;
                end else begin
                  rx_overflow <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else if (fall_p && (bit_cnt != '0)) begin
              tx_sh <= tx_sh << 1;
              miso  <= tx_sh[DATA_W-2];
            end
          end
          RELOAD: begin
            // The falling edge closing one frame presents the next frame's MSB.
            if (fall_p) begin
              tx_sh       <= ld_word;
              miso        <= ld_word[DATA_W-1];
              tx_ready    <= tx_valid;
              tx_underrun <= ~tx_valid;
              bit_cnt     <= '0;
              state       <= SHIFT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
